// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared constants for the cache/memory arbiter.
// Holds the state encoding, block geometry and owner encoding.
package cache_arb_pkg;

  localparam int BLK_WORDS = 8;
  localparam int IDX_W     = $clog2(BLK_WORDS);
  localparam int OFF_MASK  = 2 * BLK_WORDS - 1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_FILL_I = 2'd1;
  localparam state_t S_FILL_D = 2'd2;
  localparam state_t S_STORE  = 2'd3;

  typedef logic own_t;

  localparam own_t OWN_I = 1'b0;
  localparam own_t OWN_D = 1'b1;

endpackage

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: combinational winner select between I and D requests.
// Ports: i_req, d_req, rr_ptr/contend (CACHE_ARB_ROUND_ROBIN_EN), win_i, win_d.
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  own_t rr_ptr,
  output logic contend,
`endif
  output logic win_i,
  output logic win_d
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign contend = i_req && d_req;
  assign win_d   = d_req && (!i_req || rr_ptr == OWN_D);
`else
  assign win_d   = d_req;
`endif
  assign win_i   = i_req && !win_d;

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between I-fill and D fill/store.
// Ports: clk, rst_n, i_*/d_* requests, mem_* port, grants, returns, dones.
// Option: CACHE_ARB_ROUND_ROBIN_EN alternates the winner on contention.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = BLK_WORDS,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_rdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [15:0]       rdata,
  output logic [IDX_W-1:0]  word_idx,
  output logic              i_done,
  output logic              d_done
);

  if (MEM_LATENCY < 1 || BLOCK_WORDS != BLK_WORDS) begin : g_bad_cfg
    $error("cache_mem_arbiter: unsupported configuration");
  end

  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(OFF_MASK);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(BLOCK_WORDS - 1);

  state_t             state;
  logic [ADDR_W-1:0]  base;
  logic [15:0]        wdat;
  logic [IDX_W-1:0]   iss_cnt;
  logic [IDX_W-1:0]   ret_cnt;
  logic               iss_done;
  logic               win_i;
  logic               win_d;
  logic               fill;
  logic               store;
  logic               issue;
  logic               ret;
  logic               last_ret;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  own_t rr_ptr;
  logic contend;

  cache_arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .rr_ptr (rr_ptr),
    .contend(contend),
    .win_i  (win_i),
    .win_d  (win_d)
  );

  // Loser of a contended grant wins the next contention.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr <= OWN_D;
    else if (state == S_IDLE && contend)
      rr_ptr <= win_d ? OWN_I : OWN_D;
  end
`else
  cache_arb_pick u_pick (
    .i_req(i_req),
    .d_req(d_req),
    .win_i(win_i),
    .win_d(win_d)
  );
`endif

  assign fill     = (state == S_FILL_I) || (state == S_FILL_D);
  assign store    = (state == S_STORE);
  assign issue    = fill && !iss_done;
  // Returns outside a fill are stale and dropped.
  assign ret      = fill && mem_data_valid;
  assign last_ret = ret && (ret_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base     <= '0;
      wdat     <= '0;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      iss_done <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          iss_cnt  <= '0;
          ret_cnt  <= '0;
          iss_done <= 1'b0;
          unique case (1'b1)
            win_d && d_wr: begin
              state <= S_STORE;
              base  <= d_addr;
              wdat  <= d_wdata;
            end
            win_d && !d_wr: begin
              state <= S_FILL_D;
              base  <= d_addr & ~MASK;
            end
            win_i: begin
              state <= S_FILL_I;
              base  <= i_addr & ~MASK;
            end
            default: ;
          endcase
        end
        S_FILL_I, S_FILL_D: begin
          // Issue counter parks on the last index.
          if (issue) begin
            if (iss_cnt == LAST)
              iss_done <= 1'b1;
            else
              iss_cnt <= iss_cnt + 1'b1;
          end
          if (ret && !last_ret)
            ret_cnt <= ret_cnt + 1'b1;
          if (last_ret)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = issue || store;
  assign mem_wr    = store;
  assign mem_addr  = store ? base :
                     issue ? (base | ADDR_W'({iss_cnt, 1'b0})) :
                     '0;
  assign mem_wdata = store ? wdat : '0;

  assign i_grant      = (state == S_FILL_I);
  assign d_grant      = (state == S_FILL_D) || store;
  assign i_data_valid = ret && (state == S_FILL_I);
  assign d_data_valid = ret && (state == S_FILL_D);
  assign rdata        = ret ? mem_rdata : '0;
  assign word_idx     = ret ? ret_cnt : '0;
  assign i_done       = last_ret && (state == S_FILL_I);
  assign d_done       = (last_ret && (state == S_FILL_D)) || store;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench with a latency memory model.
// Expected accesses/returns are queued by stimulus, popped by a monitor.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int LAT = 4;
  localparam int BW  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        stray = 1'b0;
  logic        mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic        i_done, d_done;
  logic [2:0]  word_idx;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .MEM_LATENCY(LAT),
    .BLOCK_WORDS(BW),
    .ADDR_W     (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .d_req         (d_req),
    .d_wr          (d_wr),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_rdata     (mem_rdata),
    .i_grant       (i_grant),
    .d_grant       (d_grant),
    .i_data_valid  (i_data_valid),
    .d_data_valid  (d_data_valid),
    .rdata         (rdata),
    .word_idx      (word_idx),
    .i_done        (i_done),
    .d_done        (d_done)
  );

  function automatic logic [15:0] memf(logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  // Memory: a read issued in cycle c returns in cycle c+LAT.
  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } rsp_t;

  rsp_t pipe [LAT] = '{default: '0};

  always @(posedge clk) begin
    pipe[0] <= '{v: mem_en && !mem_wr, d: memf(mem_addr)};
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end

  assign mem_data_valid = pipe[LAT-1].v | stray;
  assign mem_rdata      = pipe[LAT-1].d;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        od;
  } acc_t;

  typedef struct {
    logic        od;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } ret_t;

  acc_t exp_acc[$];
  ret_t exp_ret[$];
  int   store_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   i_dn = 0;
  int   d_dn = 0;
  int   first_iss = 0;
  int   prev_iss = 0;
  bit   mon_en = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  bit   rr_d = 1'b1;
`endif

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_fill(bit od, logic [15:0] a);
    logic [15:0] b;
    logic [15:0] wa;
    b = a & ~16'h000F;
    for (int k = 0; k < BW; k++) begin
      wa = b + 16'(2 * k);
      exp_acc.push_back('{wr: 1'b0, addr: wa, wd: 16'h0, od: od});
      exp_ret.push_back('{od: od, idx: 3'(k), data: memf(wa),
                          last: (k == BW - 1)});
    end
  endfunction

  function automatic void push_store(logic [15:0] a, logic [15:0] w);
    exp_acc.push_back('{wr: 1'b1, addr: a, wd: w, od: 1'b1});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every memory access and every returned word.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (mem_en) begin
        if (exp_acc.size() == 0) begin
          chk("spurious_mem_access", 1, 0);
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk("mem_wr", mem_wr, a.wr);
          chk("mem_addr", mem_addr, a.addr);
          chk("mem_wdata", mem_wdata, a.wd);
          chk("grant_owner", {i_grant, d_grant},
              a.od ? 2'b01 : 2'b10);
          if (a.wr) begin
            chk("store_done", d_done, 1);
            store_cyc.push_back(cyc);
          end else if (a.addr[3:0] == 4'h0) begin
            first_iss = cyc;
          end else begin
            chk("issue_spacing", cyc - prev_iss, 1);
          end
          if (!a.wr) prev_iss = cyc;
        end
      end
      if (i_data_valid || d_data_valid) begin
        if (exp_ret.size() == 0) begin
          chk("spurious_return", {i_data_valid, d_data_valid}, 0);
        end else begin
          ret_t r;
          r = exp_ret.pop_front();
          chk("return_owner", {i_data_valid, d_data_valid},
              r.od ? 2'b01 : 2'b10);
          chk("return_grant", {i_grant, d_grant},
              r.od ? 2'b01 : 2'b10);
          chk("word_idx", word_idx, r.idx);
          chk("rdata", rdata, r.data);
          chk("done_with_return", {i_done, d_done},
              r.last ? (r.od ? 2'b01 : 2'b10) : 2'b00);
          // issues at n+1..n+8, last word at n+8+LAT
          if (r.last)
            chk("fill_latency", cyc - first_iss, BW - 1 + LAT);
        end
      end else if (i_done || (d_done && !(mem_en && mem_wr))) begin
        chk("done_without_return", {i_done, d_done}, 0);
      end
      if (i_done) i_dn++;
      if (d_done) d_dn++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_mem_side"},
        {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
    chk({tag, "_req_side"},
        {i_grant, d_grant, i_data_valid, d_data_valid,
         rdata, word_idx, i_done, d_done}, 0);
  endtask

  task automatic drained(string tag);
    chk({tag, "_acc_left"}, exp_acc.size(), 0);
    chk({tag, "_ret_left"}, exp_ret.size(), 0);
    exp_acc.delete();
    exp_ret.delete();
  endtask

  task automatic run(bit ir, logic [15:0] ia, bit dr, bit dw,
                     logic [15:0] da, logic [15:0] wd);
    bit d_first;
    int i0;
    int d0;
    int t;
    d_first = dr;
    if (ir && dr) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      d_first = rr_d;
      rr_d = !d_first;
`else
      d_first = 1'b1;
`endif
    end
    if (d_first) begin
      if (dw) push_store(da, wd);
      else push_fill(1'b1, da);
      if (ir) push_fill(1'b0, ia);
    end else begin
      if (ir) push_fill(1'b0, ia);
      if (dr) begin
        if (dw) push_store(da, wd);
        else push_fill(1'b1, da);
      end
    end
    i0 = i_dn;
    d0 = d_dn;
    i_req = ir;
    i_addr = ia;
    d_req = dr;
    d_wr = dw;
    d_addr = da;
    d_wdata = wd;
    for (t = 0; t < 400; t++) begin
      step();
      if (i_req && i_dn > i0) i_req = 1'b0;
      if (d_req && d_dn > d0) d_req = 1'b0;
      if (!i_req && !d_req) break;
    end
    if (t == 400) begin
      chk("txn_timeout", 1, 0);
      i_req = 1'b0;
      d_req = 1'b0;
    end
    step();
    drained("txn");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0;
    int d0;
    int t;
    int sel;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rw;

    repeat (6) step();
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Single I fill.
    run(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);

    // Two contended fills in a row.
    run(1'b1, 16'h2222, 1'b1, 1'b0, 16'h4444, 16'h0);
    run(1'b1, 16'h3330, 1'b1, 1'b0, 16'h6668, 16'h0);

    // Store, with stray returns in IDLE and STORE.
    push_store(16'h0A06, 16'hBEEF);
    d0 = d_dn;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0A06;
    d_wdata = 16'hBEEF;
    stray = 1'b1;
    step();
    d_req = 1'b0;
    step();
    stray = 1'b0;
    chk("store_done_count", d_dn - d0, 1);
    step();
    drained("store");

    // Request dropped and address changed mid-fill.
    push_fill(1'b0, 16'h5678);
    i0 = i_dn;
    i_req = 1'b1;
    i_addr = 16'h5678;
    repeat (3) step();
    i_req = 1'b0;
    i_addr = 16'hFFFF;
    for (t = 0; t < 100 && i_dn == i0; t++) step();
    chk("drop_fill_done", i_dn - i0, 1);
    step();
    drained("drop");

    // Reset with three returns outstanding.
    push_fill(1'b0, 16'h0BA0);
    i_req = 1'b1;
    i_addr = 16'h0BA0;
    for (t = 0; t < 100 && exp_ret.size() > 3; t++) step();
    chk("pre_reset_returns_left", exp_ret.size(), 3);
    exp_acc.delete();
    exp_ret.delete();
    i_req = 1'b0;
    rst_n = 1'b0;
    step();
    chk_zero("midfill_reset");
    rst_n = 1'b1;
    repeat (8) step();
    run(1'b1, 16'h0C0C, 1'b0, 1'b0, 16'h0, 16'h0);

    // D store held across its done: one dead cycle between.
    push_store(16'h0100, 16'h1111);
    push_store(16'h0100, 16'h1111);
    store_cyc.delete();
    d0 = d_dn;
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0100;
    d_wdata = 16'h1111;
    for (t = 0; t < 20 && d_dn - d0 < 2; t++) step();
    d_req = 1'b0;
    step();
    step();
    chk("held_store_count", store_cyc.size(), 2);
    if (store_cyc.size() == 2)
      chk("held_store_gap", store_cyc[1] - store_cyc[0], 2);
    drained("held");

    // Randomized mix.
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 2);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rw = 16'($urandom);
      run(sel != 1, ra, sel != 0, 1'($urandom_range(0, 1)), rb, rw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
